itcm_loader: RTL and testbench

//  Initiator side of the ITCM single-port RAM interface. Accepts a boot image
//  as a byte stream (valid/ready) and assembles it into little-endian 32-bit

---
 rtl/itcm_loader.sv | 170 +++++++++++++++++
 tb/tb_itcm_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/itcm_loader.sv
// Boot-image loader: packs a byte stream into little-endian words and writes them to the ITCM.
// Optional read-back verify of every written word when ITCM_LOADER_VERIFY_EN is defined.
module itcm_loader #(
   parameter int unsigned ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH+2:0] len_bytes,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] itcm_addr,
   output logic [31:0]           itcm_wr_data,
   output logic                  itcm_wr_en,
   output logic [3:0]            itcm_wr_byte_en,
   input  logic [31:0]           itcm_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 3;
   localparam int unsigned SUM_WIDTH = LEN_WIDTH + 1;

   typedef enum logic [2:0] {IDLE, RECV, WRITE, VRD, VCMP} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic [3:0]            mask_q, mask_d;
   logic [1:0]            lane_q, lane_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  word_end;

   // Range check is done one bit wider so base + word count cannot overflow.
   logic [SUM_WIDTH-1:0] words_needed;
   logic [SUM_WIDTH-1:0] end_addr;
   logic                 range_bad;

   assign words_needed = ({1'b0, len_bytes} + SUM_WIDTH'(3)) >> 2;
   assign end_addr     = SUM_WIDTH'(base_addr) + words_needed;
   assign range_bad    = end_addr > (SUM_WIDTH'(1) << ADDR_WIDTH);

`ifdef ITCM_LOADER_VERIFY_EN
   logic [31:0] mask32;
   logic        verify_bad;

   assign mask32     = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
   assign verify_bad = |((itcm_rd_data ^ data_q) & mask32);
`else
   logic unused_rd_data;

   assign unused_rd_data = ^itcm_rd_data;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      mask_d   = mask_q;
      lane_d   = lane_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      err_d    = err_q;
      word_end = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               err_d = 1'b0;
               if (len_bytes == '0) begin
                  done_d = 1'b1;
               end else if (range_bad) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = RECV;
                  addr_d  = base_addr;
                  rem_d   = len_bytes;
                  lane_d  = 2'd0;
                  mask_d  = 4'h0;
               end
            end
         end
         RECV: begin
            if (s_valid) begin
               data_d[{lane_q, 3'b000} +: 8] = s_data;
               mask_d[lane_q]                = 1'b1;
               lane_d                        = lane_q + 2'd1;
               if (rem_q != '0) begin
                  rem_d = rem_q - LEN_WIDTH'(1);
               end
               if (lane_q == 2'd3 || rem_q == LEN_WIDTH'(1)) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
`ifdef ITCM_LOADER_VERIFY_EN
            state_d = VRD;
`else
            word_end = 1'b1;
`endif
         end
`ifdef ITCM_LOADER_VERIFY_EN
         VRD: begin
            state_d = VCMP;
         end
         VCMP: begin
            if (verify_bad) begin
               err_d = 1'b1;
            end
            word_end = 1'b1;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      if (word_end) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
         mask_d = 4'h0;
         lane_d = 2'd0;
         if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = RECV;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         mask_q  <= 4'h0;
         lane_q  <= 2'd0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         lane_q  <= lane_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Strobes decode straight from state so reset removes them without waiting for a clock.
   assign s_ready         = (state_q == RECV);
   assign itcm_wr_en      = (state_q == WRITE);
   assign itcm_wr_byte_en = (state_q == WRITE) ? mask_q : 4'h0;
   assign busy            = (state_q != IDLE);
   assign itcm_addr       = addr_q;
   assign itcm_wr_data    = data_q;
   assign done            = done_q;
   assign err             = err_q;

endmodule

// File: tb/tb_itcm_loader.sv
// Self-checking bench for itcm_loader: table vectors, reset/verify sequences, random loads.
// Build with ITCM_LOADER_VERIFY_EN defined to exercise the read-back verify path.
module tb_itcm_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [13:0] base_addr = '0;
   logic [16:0] len_bytes = '0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_ready;
   logic [13:0] itcm_addr;
   logic [31:0] itcm_wr_data;
   logic        itcm_wr_en;
   logic [3:0]  itcm_wr_byte_en;
   logic [31:0] itcm_rd_data;
   logic        busy;
   logic        done;
   logic        err;

`ifdef ITCM_LOADER_VERIFY_EN
   localparam int CPW = 7;
`else
   localparam int CPW = 5;
`endif

   itcm_loader #(.ADDR_WIDTH(14)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .base_addr       (base_addr),
      .len_bytes       (len_bytes),
      .s_valid         (s_valid),
      .s_data          (s_data),
      .s_ready         (s_ready),
      .itcm_addr       (itcm_addr),
      .itcm_wr_data    (itcm_wr_data),
      .itcm_wr_en      (itcm_wr_en),
      .itcm_wr_byte_en (itcm_wr_byte_en),
      .itcm_rd_data    (itcm_rd_data),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   typedef struct {
      int          base;
      int          len;
      logic [7:0]  first;
      logic        exp_err;
      int          exp_writes;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      logic [3:0]  exp_last_be;
   } vec_t;

   wr_t         wlog[$];
   logic [31:0] mem [0:16383];
   logic [7:0]  img [0:63];
   logic [31:0] rd_q = '0;
   logic        corrupt_en = 1'b0;
   logic [13:0] corrupt_addr = '0;
   int          done_cnt = 0;
   int          busy_cnt = 0;
   int          rdy_cnt = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   assign itcm_rd_data = rd_q;

   // ITCM model with 1-cycle read latency; optional bit-0 corruption on one address.
   always @(posedge clk) begin
      wr_t e;
      if (itcm_wr_en) begin
         e.addr = itcm_addr;
         e.data = itcm_wr_data;
         e.be   = itcm_wr_byte_en;
         wlog.push_back(e);
         for (int b = 0; b < 4; b++) begin
            if (itcm_wr_byte_en[b]) mem[itcm_addr][8*b +: 8] <= itcm_wr_data[8*b +: 8];
         end
      end
      rd_q <= mem[itcm_addr] ^ {31'b0, corrupt_en && (itcm_addr == corrupt_addr)};
      if (done)    done_cnt <= done_cnt + 1;
      if (busy)    busy_cnt <= busy_cnt + 1;
      if (s_ready) rdy_cnt  <= rdy_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // Runs one load of img[0..len-1] and checks it against the word-level model.
   task automatic run_load(input int base, input int len, input int pct, input bit vfy_err,
                           input string tag, output int n_wr);
      int          w0, d0, b0, r0, ptr, nw, exp_wr, exp_bytes, nb;
      bit          bad, got_done;
      logic [31:0] exp_data;
      logic [3:0]  exp_be;
      nw        = (len + 3) / 4;
      bad       = (base + nw) > 16384;
      exp_wr    = bad ? 0 : nw;
      exp_bytes = bad ? 0 : len;
      w0 = wlog.size();
      d0 = done_cnt;
      b0 = busy_cnt;
      r0 = rdy_cnt;
      @(negedge clk);
      start     = 1'b1;
      base_addr = 14'(base);
      len_bytes = 17'(len);
      @(negedge clk);
      start    = 1'b0;
      ptr      = 0;
      got_done = 1'b0;
      for (int c = 0; c < len * 60 + 20; c++) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         s_valid = ($urandom_range(0, 99) < pct);
         s_data  = (ptr < 64) ? img[ptr] : 8'h00;
         if (s_valid && s_ready) ptr++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_wr = wlog.size() - w0;
      check({tag, " done_seen"}, 32'(got_done), 32'd1);
      check({tag, " done_pulses"}, done_cnt - d0, 32'd1);
      check({tag, " err"}, 32'(err), 32'(bad || vfy_err));
      check({tag, " n_writes"}, n_wr, exp_wr);
      check({tag, " bytes_taken"}, ptr, exp_bytes);
      for (int w = 0; w < exp_wr && w < n_wr; w++) begin
         nb       = (len - 4 * w > 4) ? 4 : len - 4 * w;
         exp_be   = 4'((1 << nb) - 1);
         exp_data = '0;
         for (int k = 0; k < nb; k++) exp_data[8*k +: 8] = img[4*w + k];
         check($sformatf("%s w%0d addr", tag, w), 32'(wlog[w0+w].addr), 32'(base + w));
         check($sformatf("%s w%0d be", tag, w), 32'(wlog[w0+w].be), 32'(exp_be));
         check($sformatf("%s w%0d data", tag, w),
               wlog[w0+w].data & be_to_mask(exp_be), exp_data);
      end
      if (bad || len == 0) begin
         check({tag, " busy_cycles"}, busy_cnt - b0, 32'd0);
         check({tag, " ready_cycles"}, rdy_cnt - r0, 32'd0);
      end else if (pct == 100) begin
         check({tag, " busy_cycles"}, busy_cnt - b0, len + nw * (CPW - 4));
      end
   endtask

   vec_t vecs [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n_wr, ptr, base, len, pct;
      bit seen;
      logic [31:0] m;

      vecs[0] = '{0,     8,  8'h01, 1'b0, 2, 32'h04030201, 32'h08070605, 4'hF};
      vecs[1] = '{10,    6,  8'hAA, 1'b0, 2, 32'hADACABAA, 32'h0000AFAE, 4'h3};
      vecs[2] = '{16380, 20, 8'h00, 1'b1, 0, 32'h0,        32'h0,        4'h0};
      vecs[3] = '{7,     0,  8'h00, 1'b0, 0, 32'h0,        32'h0,        4'h0};
      vecs[4] = '{16383, 4,  8'h10, 1'b0, 1, 32'h13121110, 32'h13121110, 4'hF};
      vecs[5] = '{16383, 5,  8'h20, 1'b1, 0, 32'h0,        32'h0,        4'h0};
      vecs[6] = '{100,   1,  8'h55, 1'b0, 1, 32'h00000055, 32'h00000055, 4'h1};
      vecs[7] = '{200,   3,  8'h60, 1'b0, 1, 32'h00626160, 32'h00626160, 4'h7};
      vecs[8] = '{16376, 32, 8'h80, 1'b0, 8, 32'h83828180, 32'h9F9E9D9C, 4'hF};

      #1;
      check("rst wr_en", 32'(itcm_wr_en), 32'd0);
      check("rst s_ready", 32'(s_ready), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst err", 32'(err), 32'd0);
      check("rst addr", 32'(itcm_addr), 32'd0);
      check("rst wr_data", itcm_wr_data, 32'd0);
      check("rst byte_en", 32'(itcm_wr_byte_en), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         for (int j = 0; j < 64; j++) img[j] = vecs[i].first + 8'(j);
         run_load(vecs[i].base, vecs[i].len, (i % 2 == 0) ? 100 : 60, 1'b0,
                  $sformatf("vec%0d", i), n_wr);
         check($sformatf("vec%0d tbl_err", i), 32'(err), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d tbl_writes", i), n_wr, vecs[i].exp_writes);
         if (n_wr > 0 && n_wr == vecs[i].exp_writes) begin
            m = (n_wr == 1) ? be_to_mask(vecs[i].exp_last_be) : 32'hFFFF_FFFF;
            check($sformatf("vec%0d tbl_first", i), wlog[wlog.size()-n_wr].data & m,
                  vecs[i].exp_first);
            check($sformatf("vec%0d tbl_last", i),
                  wlog[wlog.size()-1].data & be_to_mask(vecs[i].exp_last_be),
                  vecs[i].exp_last);
            check($sformatf("vec%0d tbl_last_be", i), 32'(wlog[wlog.size()-1].be),
                  32'(vecs[i].exp_last_be));
         end
      end

      // Reset landing on a WRITE cycle must drop wr_en at once.
      for (int j = 0; j < 64; j++) img[j] = 8'h30 + 8'(j);
      @(negedge clk);
      start     = 1'b1;
      base_addr = 14'd5;
      len_bytes = 17'd8;
      @(negedge clk);
      start   = 1'b0;
      s_valid = 1'b1;
      ptr     = 0;
      seen    = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (itcm_wr_en) begin
            seen = 1'b1;
            break;
         end
         s_data = img[ptr];
         if (s_ready) ptr++;
         @(negedge clk);
      end
      check("rstw write_reached", 32'(seen), 32'd1);
      rst = 1'b1;
      #1;
      check("rstw wr_en", 32'(itcm_wr_en), 32'd0);
      check("rstw busy", 32'(busy), 32'd0);
      check("rstw s_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      rst     = 1'b0;
      s_valid = 1'b0;
      run_load(5, 8, 100, 1'b0, "rstw reload", n_wr);

`ifdef ITCM_LOADER_VERIFY_EN
      for (int j = 0; j < 64; j++) img[j] = 8'(j + 1);
      corrupt_addr = 14'd1;
      corrupt_en   = 1'b1;
      run_load(0, 12, 100, 1'b1, "verify", n_wr);
      corrupt_en = 1'b0;
`endif

      for (int t = 0; t < 30; t++) begin
         base = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 16383)
                                            : 16384 - $urandom_range(1, 12);
         len  = $urandom_range(0, 40);
         pct  = ($urandom_range(0, 3) == 0) ? 100 : $urandom_range(20, 99);
         for (int j = 0; j < 64; j++) img[j] = 8'($urandom);
         run_load(base, len, pct, 1'b0, $sformatf("rnd%0d", t), n_wr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
